// File: rtl/dbg_pkg.sv
// Shared constants for the debug-probe LED selector.
// Mode encoding matches the two top DIP switches, sw[15:14].
// No state, no flow control.
package dbg_pkg;

    localparam logic [1:0] MODE_LIVE   = 2'b00;
    localparam logic [1:0] MODE_FREEZE = 2'b01;
    localparam logic [1:0] MODE_SCAN   = 2'b10;
    localparam logic [1:0] MODE_TRIG   = 2'b11;

    localparam int DBG_W   = 16;
    localparam int DBG_NCH = 64;

endpackage

// File: rtl/dbg_chan_mux.sv
// Combinational slice of one W-bit channel out of the flat probe bus.
// Latency: zero (pure combinational); out-of-range index yields dflt.
// Backpressure: none.
module dbg_chan_mux #(
    parameter int NCH   = dbg_pkg::DBG_NCH,
    parameter int W     = dbg_pkg::DBG_W,
    parameter int SEL_W = 6
) (
    input  logic [NCH*W-1:0] probe_bus,
    input  logic [SEL_W-1:0] idx,
    input  logic [W-1:0]     dflt,
    output logic [W-1:0]     dat
);

    always_comb begin
        dat = dflt;
        for (int k = 0; k < NCH; k++) begin
            if (idx == SEL_W'(k)) begin
                dat = probe_bus[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/dbg_probe_mux.sv
// Registered debug-probe selector driving the LED bank: live/freeze/scan/trigger modes.
// Latency: one cycle from sw/probe_bus/trig to led_data, cur_ch and trig_hit.
// Backpressure: none; inputs are sampled every cycle.
module dbg_probe_mux
    import dbg_pkg::*;
#(
    parameter int NCH      = DBG_NCH,
    parameter int W        = DBG_W,
    parameter int SEL_W    = 6,
    parameter int SCAN_DIV = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      sw,
    input  logic [NCH*W-1:0] probe_bus,
    input  logic             trig,
    output logic [W-1:0]     led_data,
    output logic [SEL_W-1:0] cur_ch,
    output logic             trig_hit
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CP_W  = (W < 16) ? W : 16;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(NCH - 1);

    logic [1:0]       mode;
    logic [SEL_W-1:0] sel;
    logic [W-1:0]     sw_fit;
    logic [W-1:0]     sel_dat;
    logic [W-1:0]     scan_dat;

    logic [W-1:0]     snap_q, snap_nxt;
    logic [W-1:0]     cap_q, cap_nxt;
    logic [DIV_W-1:0] div_q, div_nxt;
    logic [SEL_W-1:0] scan_q, scan_nxt;
    logic [SEL_W-1:0] sel_q;
    logic [1:0]       prev_mode;
    logic             armed_q, armed_nxt;
    logic             trig_q;
    logic [W-1:0]     led_nxt;
    logic [SEL_W-1:0] cur_nxt;
    logic             hit_nxt;

    logic             trig_rise;
    logic             trig_entry;
    logic             sel_chg;

    assign mode = sw[15:14];
    assign sel  = sw[SEL_W-1:0];

    // Out-of-range selects show the raw switch word, resized to the LED width.
    always_comb begin
        sw_fit = '0;
        sw_fit[CP_W-1:0] = sw[CP_W-1:0];
    end

    dbg_chan_mux #(.NCH(NCH), .W(W), .SEL_W(SEL_W)) u_sel_mux (
        .probe_bus (probe_bus),
        .idx       (sel),
        .dflt      (sw_fit),
        .dat       (sel_dat)
    );

    dbg_chan_mux #(.NCH(NCH), .W(W), .SEL_W(SEL_W)) u_scan_mux (
        .probe_bus (probe_bus),
        .idx       (scan_q),
        .dflt      ('0),
        .dat       (scan_dat)
    );

    assign trig_rise  = trig & ~trig_q;
    assign trig_entry = (prev_mode != MODE_TRIG);
    assign sel_chg    = (sel != sel_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            led_data  <= '0;
            cur_ch    <= '0;
            trig_hit  <= 1'b0;
            snap_q    <= '0;
            cap_q     <= '0;
            div_q     <= '0;
            scan_q    <= '0;
            armed_q   <= 1'b0;
            trig_q    <= 1'b0;
            prev_mode <= MODE_LIVE;
            sel_q     <= '0;
        end else begin
            led_data  <= led_nxt;
            cur_ch    <= cur_nxt;
            trig_hit  <= hit_nxt;
            snap_q    <= snap_nxt;
            cap_q     <= cap_nxt;
            div_q     <= div_nxt;
            scan_q    <= scan_nxt;
            armed_q   <= armed_nxt;
            trig_q    <= trig;
            prev_mode <= mode;
            sel_q     <= sel;
        end
    end

    always_comb begin
        led_nxt   = led_data;
        cur_nxt   = cur_ch;
        hit_nxt   = 1'b0;
        snap_nxt  = snap_q;
        cap_nxt   = cap_q;
        div_nxt   = div_q;
        scan_nxt  = scan_q;
        armed_nxt = armed_q;

        case (mode)
            MODE_LIVE: begin
                led_nxt = sel_dat;
                cur_nxt = sel;
            end

            MODE_FREEZE: begin
                if (prev_mode != MODE_FREEZE) begin
                    snap_nxt = sel_dat;
                    led_nxt  = sel_dat;
                    cur_nxt  = sel;
                end else begin
                    led_nxt  = snap_q;
                end
            end

            MODE_SCAN: begin
                led_nxt = scan_dat;
                cur_nxt = scan_q;
                if (div_q == DIV_LAST) begin
                    div_nxt  = '0;
                    scan_nxt = (scan_q == CH_LAST) ? '0 : scan_q + 1'b1;
                end else begin
                    div_nxt  = div_q + 1'b1;
                end
            end

            default: begin
                cur_nxt = sel;
                // A select change inside TRIG re-arms and beats a same-cycle edge.
                if (!trig_entry && sel_chg) begin
                    armed_nxt = 1'b1;
                    led_nxt   = sel_dat;
                end else if (trig_entry || armed_q) begin
                    led_nxt = sel_dat;
                    if (trig_rise) begin
                        cap_nxt   = sel_dat;
                        armed_nxt = 1'b0;
                        hit_nxt   = 1'b1;
                    end else begin
                        armed_nxt = 1'b1;
                    end
                end else begin
                    led_nxt = cap_q;
                    hit_nxt = trig_hit;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_dbg_probe_mux.sv
// Self-checking bench for dbg_probe_mux (NCH=4, W=16, SEL_W=3, SCAN_DIV=3).
// Expected outputs are queued per driven cycle and compared one edge later.
module tb_dbg_probe_mux;

    localparam int NCH = 4;
    localparam int W = 16;
    localparam int SEL_W = 3;
    localparam int SCAN_DIV = 3;

    typedef struct packed {
        logic [15:0] led;
        logic [2:0]  ch;
        logic        hit;
    } obs_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0]       sw;
    logic              trig;
    logic [15:0]       ch [4];
    logic [NCH*W-1:0]  probe_bus;
    logic [W-1:0]      led_data;
    logic [SEL_W-1:0]  cur_ch;
    logic              trig_hit;

    logic [15:0] base [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    int n_err = 0;
    int n_chk = 0;
    obs_t sb [$];

    // Reference model state
    logic [15:0] m_led, m_snap, m_cap;
    logic [2:0]  m_cur, m_scan, m_selq;
    logic        m_hit, m_armed, m_trq;
    logic [1:0]  m_pmode;
    int          m_div;

    assign probe_bus = {ch[3], ch[2], ch[1], ch[0]};

    always #5 clk = ~clk;

    dbg_probe_mux #(.NCH(NCH), .W(W), .SEL_W(SEL_W), .SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .probe_bus (probe_bus),
        .trig      (trig),
        .led_data  (led_data),
        .cur_ch    (cur_ch),
        .trig_hit  (trig_hit)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance the model by one edge using the inputs currently driven.
    task automatic model_step();
        logic [1:0]  md;
        logic [2:0]  s;
        logic [15:0] lv;
        logic        rise;
        md = sw[15:14];
        s  = sw[2:0];
        lv = (int'(s) < NCH) ? ch[s] : sw;
        if (!rst) begin
            m_led = 0; m_cur = 0; m_hit = 0; m_snap = 0; m_cap = 0;
            m_div = 0; m_scan = 0; m_armed = 0; m_trq = 0; m_pmode = 0; m_selq = 0;
            return;
        end
        rise = trig && !m_trq;
        m_hit = 1'b0;
        if (md == 2'b00) begin
            m_led = lv;
            m_cur = s;
        end else if (md == 2'b01) begin
            if (m_pmode != 2'b01) begin
                m_snap = lv;
                m_cur = s;
            end
            m_led = m_snap;
        end else if (md == 2'b10) begin
            m_led = ch[m_scan];
            m_cur = m_scan;
            m_div = m_div + 1;
            if (m_div == SCAN_DIV) begin
                m_div = 0;
                m_scan = 3'((int'(m_scan) + 1) % NCH);
            end
        end else begin
            m_cur = s;
            if (m_pmode != 2'b11) m_armed = 1'b1;
            else if (s != m_selq) begin
                m_armed = 1'b1;
                rise = 1'b0;
            end
            if (m_armed && rise) begin
                m_cap = lv;
                m_armed = 1'b0;
                m_hit = 1'b1;
                m_led = m_cap;
            end else if (m_armed) begin
                m_led = lv;
            end else begin
                m_led = m_cap;
                m_hit = 1'b1;
            end
        end
        m_trq = trig;
        m_pmode = md;
        m_selq = s;
    endtask

    task automatic cyc();
        obs_t e;
        model_step();
        sb.push_back({m_led, m_cur, m_hit});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_underflow", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("sb_led", led_data, e.led);
            chk("sb_ch", cur_ch, e.ch);
            chk("sb_hit", trig_hit, e.hit);
        end
    endtask

    function automatic logic [15:0] mk_sw(input logic [1:0] md, input logic [2:0] s);
        return {md, 11'b0, s};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 4; i++) ch[i] = base[i];
        rst = 1'b0;
        trig = 1'b0;
        sw = mk_sw(2'b00, 3'd2);

        // 1: reset, then live sel=2
        cyc(); cyc();
        chk("rst_led", led_data, 0);
        chk("rst_ch", cur_ch, 0);
        chk("rst_hit", trig_hit, 0);
        rst = 1'b1;
        cyc();
        chk("live_led", led_data, 16'h3333);
        chk("live_ch", cur_ch, 2);

        // 2: out-of-range select shows switch word
        sw = mk_sw(2'b00, 3'd6);
        cyc();
        chk("oor_led", led_data, 16'h0006);

        // 3: freeze entered on ch1, later changes ignored
        sw = mk_sw(2'b01, 3'd1);
        cyc();
        chk("frz_entry_led", led_data, 16'h2222);
        ch[1] = 16'hBEEF;
        sw = mk_sw(2'b01, 3'd3);
        cyc(); cyc(); cyc();
        chk("frz_led", led_data, 16'h2222);
        chk("frz_ch", cur_ch, 1);
        ch[1] = base[1];

        // 4: auto-scan, one step per SCAN_DIV cycles, resume after leaving
        sw = mk_sw(2'b10, 3'd0);
        for (int k = 0; k < 15; k++) begin
            cyc();
            chk("scan_ch", cur_ch, (k / 3) % 4);
            chk("scan_led", led_data, base[(k / 3) % 4]);
        end
        sw = mk_sw(2'b00, 3'd0);
        cyc(); cyc(); cyc();
        sw = mk_sw(2'b10, 3'd0);
        cyc();
        chk("scan_resume_ch", cur_ch, 1);
        chk("scan_resume_led", led_data, 16'h2222);
        cyc(); cyc(); cyc();
        chk("scan_resume_step", cur_ch, 2);

        // 5: trigger capture on ch0
        sw = mk_sw(2'b11, 3'd0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("trig_armed_hit", trig_hit, 0);
        end
        trig = 1'b1;
        cyc();
        chk("cap_led", led_data, 16'h1111);
        chk("cap_hit", trig_hit, 1);
        trig = 1'b0;
        ch[0] = 16'h5555;
        cyc();
        chk("cap_hold_led", led_data, 16'h1111);
        trig = 1'b1; cyc();
        trig = 1'b0; cyc();
        chk("no_recap_led", led_data, 16'h1111);
        chk("no_recap_hit", trig_hit, 1);
        sw = mk_sw(2'b11, 3'd1);
        cyc();
        chk("rearm_hit", trig_hit, 0);
        chk("rearm_led", led_data, 16'h2222);
        // select change and edge together: re-arm wins
        sw = mk_sw(2'b11, 3'd2);
        trig = 1'b1;
        cyc();
        chk("rearm_wins_hit", trig_hit, 0);
        cyc();
        chk("level_no_cap", trig_hit, 0);
        trig = 1'b0; cyc();
        trig = 1'b1; cyc();
        chk("cap2_led", led_data, 16'h3333);
        chk("cap2_hit", trig_hit, 1);

        // 6: reset mid-capture with trig held high
        rst = 1'b0;
        cyc();
        chk("rst2_led", led_data, 0);
        chk("rst2_ch", cur_ch, 0);
        chk("rst2_hit", trig_hit, 0);
        rst = 1'b1;
        cyc();
        ch[2] = 16'h7777;
        cyc(); cyc(); cyc();
        chk("post_rst_single_cap", led_data, 16'h3333);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dbg_probe_mux.md
# dbg_probe_mux

Parametrised, registered debug-probe selector driving the board LED bank from the DIP switches. It succeeds the fixed 16-bit combinational LED mux and generalises it to NCH channels of W bits. It adds four display modes: live, freeze, auto-scan and trigger-capture. It sits at top level beside the CPU pipeline; every stage drops its debug signals onto a flat probe bus.

## Interface
Parameters:
- NCH, 64: number of probe channels.
- W, 16: channel width; also LED width.
- SEL_W, 6: channel-select width; must satisfy 2^SEL_W >= NCH and SEL_W <= 13.
- SCAN_DIV, 25000000: clock cycles per channel in auto-scan; must be >= 1.

Ports (one clock; reset is synchronous and active-low):
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-low reset.
- sw, in, 16: sw[15:14] = mode; sw[SEL_W-1:0] = channel select.
- probe_bus, in, NCH*W: channel k occupies bits [k*W+W-1 : k*W].
- trig, in, 1: trigger event line, level signal sampled on clk.
- led_data, out, W: registered display value.
- cur_ch, out, SEL_W: channel currently displayed; registered.
- trig_hit, out, 1: high while a trigger capture is held.

## Operation
Mode encoding:
- 00 LIVE: display probe[sel].
- 01 FREEZE: display the snapshot.
- 10 SCAN: display probe[scan_ch].
- 11 TRIG: display the capture register.

Rules by mode:
- Out-of-range select (sel >= NCH) in LIVE, FREEZE or TRIG:
  - led_data = sw zero-extended or truncated to W.
  - The snapshot or capture still loads from the sw value.
- FREEZE:
  - The snapshot loads probe[sel] on the first cycle mode==01 while the previous mode != 01.
  - Later select changes in FREEZE are ignored.
  - cur_ch holds the select latched at entry.
- SCAN:
  - A prescaler div counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1, div returns to 0 and scan_ch increments.
  - scan_ch wraps from NCH-1 to 0.
  - When the mode is not SCAN, div and scan_ch hold their values; scanning resumes from where it stopped.
- TRIG:
  - trig_q, the previous sample of trig, updates every cycle in all modes.
  - A rising edge is trig & ~trig_q.
  - Entering TRIG sets armed=1 and clears trig_hit.
  - While armed, a rising edge loads probe[sel] into the capture register and sets armed=0, trig_hit=1.
  - Until capture, led_data shows live probe[sel].
  - A select change while in TRIG re-arms and clears trig_hit.
- Leaving TRIG clears trig_hit.

## Timing
- Reset values, applied on the next edge with rst==0:
  - led_data = 0, cur_ch = 0, trig_hit = 0.
  - snapshot = 0, capture = 0, div = 0, scan_ch = 0.
  - armed = 0, trig_q = 0, prev_mode = 00.
- Reset mid-operation discards any snapshot or capture.
- Latency: one cycle. led_data at edge n+1 reflects sw, probe_bus and trig sampled at edge n.
- FREEZE entry: the snapshot value is the probe sampled at the entry edge and appears on led_data at that same edge.
- TRIG edge:
  - A rising edge detected at edge n makes led_data show the captured value from edge n onward; trig_hit=1 from edge n.
  - An edge in the same cycle as TRIG entry counts as a capture, since armed is forced 1 in that cycle.
- Simultaneous select change and trig edge in TRIG: the re-arm wins. No capture occurs and trig_hit=0.
- SCAN with SCAN_DIV=1: scan_ch advances every cycle.

## Structure
- Package dbg_pkg:
  - Mode constants MODE_LIVE, MODE_FREEZE, MODE_SCAN, MODE_TRIG (2 bits).
  - Default W and NCH.
- Sub-module dbg_chan_mux:
  - Combinational indexed slice of probe_bus by a SEL_W index.
  - Out-of-range index returns the supplied default.
  - Instantiated twice: for sel and for scan_ch.
- All state lives in dbg_probe_mux.

## Test plan
Bench config: NCH=4, W=16, SCAN_DIV=3; probes ch0..3 = 16'h1111, 16'h2222, 16'h3333, 16'h4444.

1. Reset, then mode 00, sel=2: led_data = 0 during reset. led_data = 16'h3333, cur_ch = 2 one cycle after reset is released.
2. Mode 00, sel=6 (out of range): led_data = 16'h0006, the sw value.
3. Mode 01 entered with sel=1, then ch1 changed to 16'hBEEF and sel changed to 3: led_data stays 16'h2222 and cur_ch stays 1.
4. Mode 10 for 15 cycles: cur_ch steps 0,1,2,3,0, one step every 3 cycles. led_data tracks the channel. Switching to 00 and back resumes from the held scan_ch.
5. Mode 11, sel=0; trig pulses at cycle 5; ch0 then changed to 16'h5555:
   - led_data = 16'h1111 and trig_hit = 1 from the capture edge.
   - A second pulse does not recapture.
   - Changing sel clears trig_hit and re-arms.
6. Reset asserted mid-capture in mode 11: all outputs return to 0. With trig held high, no false capture occurs after release, because trig_q restarts at 0 and only one rising edge is seen.
